// File: rtl/gpio_debounce_bank_pkg.sv
// gpio_debounce_bank_pkg
// Shared constants and helpers for the GPIO connect layer debouncers.
// Contents:
//   GPIO_TICK_HZ         default debounce sampling tick rate (Hz)
//   GPIO_DEBOUNCE_TICKS  default number of disagreeing ticks before a new level is accepted
//   GPIO_LONG_TICKS      default hold ticks for a long-press event
//   GPIO_ACTIVE_LOW      default pin polarity (1 = pressed button reads 0)
//   pb_event_e           per-channel event decided on a given cycle
//   tick_divisor()       src_clk cycles per debounce tick
package gpio_debounce_bank_pkg;

  localparam int GPIO_TICK_HZ        = 1000;
  localparam int GPIO_DEBOUNCE_TICKS = 40;
  localparam int GPIO_LONG_TICKS     = 1000;
  localparam bit GPIO_ACTIVE_LOW     = 1'b1;

  typedef enum logic [1:0] {
    PB_EV_NONE    = 2'd0,
    PB_EV_PRESS   = 2'd1,
    PB_EV_RELEASE = 2'd2
  } pb_event_e;

  function automatic int tick_divisor(input int src_clk, input int tick_hz);
    return src_clk / tick_hz;
  endfunction

endpackage

// File: rtl/gpio_tick_gen.sv
// gpio_tick_gen
// Free-running divider producing a one-cycle enable every SRC_CLK/TICK_HZ
// cycles. No derived clock: consumers stay on src_clk and qualify with tick.
// Ports:
//   src_clk  in   sole clock, rising edge
//   rst_n    in   asynchronous active-low reset (counter returns to 0)
//   tick     out  high for one src_clk cycle when the counter is at its terminal value
`ifndef SOURCE_CLK
`define SOURCE_CLK 50_000_000
`endif

module gpio_tick_gen
  import gpio_debounce_bank_pkg::*;
#(
  parameter int SRC_CLK = `SOURCE_CLK,
  parameter int TICK_HZ = GPIO_TICK_HZ
) (
  input  logic src_clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = tick_divisor(SRC_CLK, TICK_HZ);
  localparam int W   = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  // Refuse configurations where the tick would not be an exact integer
  // number of cycles or would be asserted continuously.
  if (DIV < 2 || (SRC_CLK % TICK_HZ) != 0) begin : g_bad_divisor
    $error("gpio_tick_gen: SRC_CLK/TICK_HZ must be an integer >= 2");
  end

  logic [W-1:0] count;

  // Counts 0..DIV-1 and wraps; tick marks the terminal value.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/gpio_debounce_bank.sv
// gpio_debounce_bank
// Multi-channel push-button debouncer: 2-flop synchroniser, polarity
// normalisation and an independent tick-based filter per channel.
// Optional long-press detection is compiled in with GPIO_DEBOUNCE_LONG_EN.
// Ports:
//   src_clk     in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   pb_in       in   raw asynchronous button pins [CHANNELS]
//   pb_level    out  debounced state, 1 = pressed regardless of polarity
//   pb_press    out  one-cycle pulse coincident with pb_level rising
//   pb_release  out  one-cycle pulse coincident with pb_level falling
//   pb_long     out  one-cycle pulse after LONG_TICKS ticks held (0 when compiled out)
`ifndef SOURCE_CLK
`define SOURCE_CLK 50_000_000
`endif

module gpio_debounce_bank
  import gpio_debounce_bank_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int SRC_CLK        = `SOURCE_CLK,
  parameter int TICK_HZ        = GPIO_TICK_HZ,
  parameter int DEBOUNCE_TICKS = GPIO_DEBOUNCE_TICKS,
  parameter bit ACTIVE_LOW     = GPIO_ACTIVE_LOW,
  parameter int LONG_TICKS     = GPIO_LONG_TICKS
) (
  input  logic                src_clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] pb_in,
  output logic [CHANNELS-1:0] pb_level,
  output logic [CHANNELS-1:0] pb_press,
  output logic [CHANNELS-1:0] pb_release,
  output logic [CHANNELS-1:0] pb_long
);

  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  // Pin level of a released button; synchronisers reset here so a button
  // held through reset looks like a fresh press, never a release.
  localparam logic [CHANNELS-1:0] IDLE_PINS = {CHANNELS{ACTIVE_LOW}};

  if (CHANNELS < 1 || DEBOUNCE_TICKS < 1 || LONG_TICKS < 1) begin : g_bad_params
    $error("gpio_debounce_bank: CHANNELS, DEBOUNCE_TICKS and LONG_TICKS must be >= 1");
  end

`ifdef GPIO_DEBOUNCE_LONG_EN
  localparam int HOLD_W = $clog2(LONG_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
`endif

  logic                tick;
  logic [CHANNELS-1:0] sync_meta;
  logic [CHANNELS-1:0] sync_out;
  logic [CHANNELS-1:0] raw;

  gpio_tick_gen #(
    .SRC_CLK(SRC_CLK),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .src_clk(src_clk),
    .rst_n  (rst_n),
    .tick   (tick)
  );

  // Two-flop synchroniser on every pin.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= IDLE_PINS;
      sync_out  <= IDLE_PINS;
    end else begin
      sync_meta <= pb_in;
      sync_out  <= sync_meta;
    end
  end

  assign raw = sync_out ^ IDLE_PINS;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             press_q;
    logic             release_q;
    pb_event_e        ev;

    // The new level is accepted on the tick that completes DEBOUNCE_TICKS
    // consecutive disagreeing ticks.
    always_comb begin
      ev = PB_EV_NONE;
      if (tick && (raw[i] != stable) && (cnt == CNT_LAST)) begin
        ev = raw[i] ? PB_EV_PRESS : PB_EV_RELEASE;
      end
    end

    // Any cycle of agreement restarts the count, so a bounce back to the
    // stable level between ticks still discards the partial count.
    always_ff @(posedge src_clk or negedge rst_n) begin
      if (!rst_n) begin
        stable    <= 1'b0;
        cnt       <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= (ev == PB_EV_PRESS);
        release_q <= (ev == PB_EV_RELEASE);
        if (raw[i] == stable) begin
          cnt <= '0;
        end else if (ev != PB_EV_NONE) begin
          stable <= raw[i];
          cnt    <= '0;
        end else if (tick) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign pb_level[i]   = stable;
    assign pb_press[i]   = press_q;
    assign pb_release[i] = release_q;

`ifdef GPIO_DEBOUNCE_LONG_EN
    logic [HOLD_W-1:0] hold;
    logic              long_q;

    // Hold counter saturates at LONG_TICKS so the long pulse fires once per press.
    always_ff @(posedge src_clk or negedge rst_n) begin
      if (!rst_n) begin
        hold   <= '0;
        long_q <= 1'b0;
      end else begin
        long_q <= 1'b0;
        if (!stable) begin
          hold <= '0;
        end else if (tick && (hold != HOLD_MAX)) begin
          hold   <= hold + HOLD_W'(1);
          long_q <= (hold == HOLD_LAST);
        end
      end
    end

    assign pb_long[i] = long_q;
`else
    assign pb_long[i] = 1'b0;
`endif
  end

endmodule

// File: doc/gpio_debounce_bank.md
# gpio_debounce_bank

Parametrised multi-channel push-button debouncer for the GPIO connect layer. It synchronises `CHANNELS` raw button inputs into the `src_clk` domain and filters each one with its own tick-based counter. For each channel it produces a clean level plus single-cycle press and release pulses. It replaces the per-button fixed-time, press-only debouncer and feeds UART command/trigger logic directly.

## Interface
- `CHANNELS`, 4: number of independent button channels (≥1).
- `SRC_CLK`, `` `SOURCE_CLK ``: `src_clk` frequency in Hz.
- `TICK_HZ`, 1000: debounce sampling tick rate. `SRC_CLK/TICK_HZ` must be an integer ≥2.
- `DEBOUNCE_TICKS`, 40: consecutive disagreeing ticks required to accept a new level (≥1).
- `ACTIVE_LOW`, 1: 1 means a pressed button drives 0 on `pb_in`.
- `LONG_TICKS`, 1000: hold ticks for a long-press event. Used only with `GPIO_DEBOUNCE_LONG_EN`.
- `src_clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pb_in` in CHANNELS: raw asynchronous button pins.
- `pb_level` out CHANNELS: debounced state, 1 = pressed, independent of polarity.
- `pb_press` out CHANNELS: one-`src_clk` pulse when `pb_level` rises.
- `pb_release` out CHANNELS: one-`src_clk` pulse when `pb_level` falls.
- `pb_long` out CHANNELS: one-cycle long-press pulse. Driven 0 when the feature is compiled out.

## Operation
- **Tick generator**
  - Free-running counter 0..`SRC_CLK/TICK_HZ`-1.
  - `tick` is high for exactly one `src_clk` cycle, when the counter is at its terminal value.
  - No derived clocks: all logic is clocked by `src_clk` and gated by `tick`.
- **Input conditioning**
  - Each `pb_in` bit passes through a 2-flop synchroniser.
  - The result is XORed with `ACTIVE_LOW` to form `raw[i]` (1 = pressed).
- **Per-channel filter** (state: `stable[i]`, counter `cnt[i]`)
  - If `raw[i] == stable[i]` on any cycle: `cnt[i]` <= 0 immediately, not only on a tick.
  - Else, on `tick` with `cnt[i] < DEBOUNCE_TICKS-1`: `cnt[i]` increments.
  - Else, on `tick` with `cnt[i] == DEBOUNCE_TICKS-1`:
    - `stable[i]` <= `raw[i]` and `cnt[i]` <= 0.
    - In the same clock edge, the matching `pb_press[i]` or `pb_release[i]` is registered high.
  - `pb_press` and `pb_release` clear on the following cycle.
  - `pb_level` = `stable`.
- **Counter width:** `cnt` is `$clog2(DEBOUNCE_TICKS+1)` bits. It never wraps, because it saturates at the accept point.
- **Channel independence:** channels never interact. Simultaneous events on several channels all pulse in the same cycle.
- **Glitch rejection:** a glitch shorter than one tick is invisible if it falls between ticks. Any return to the stable level restarts the count.

## Timing
- **Reset values:** all outputs 0, `stable` = 0 (released), `cnt` = 0, tick counter = 0, synchronisers reset to the released level.
- **Latency:** from a clean edge on `pb_in` to `pb_level`/event, 2 synchroniser cycles plus `DEBOUNCE_TICKS` ticks. The event pulse is coincident with the `pb_level` change.
- **Held through reset:** a button held pressed across reset deassertion yields one `pb_press` after the debounce time. No spurious `pb_release` is produced.
- **Reset mid-count:** reset asserted mid-count discards the count and returns to the reset state asynchronously.
- **Event spacing:** `pb_press` and `pb_release` never both assert for one channel in the same cycle. Minimum spacing between them is `DEBOUNCE_TICKS` ticks.

## Configuration
- **`GPIO_DEBOUNCE_LONG_EN` defined:**
  - Each channel adds a hold counter of `$clog2(LONG_TICKS+1)` bits.
  - The counter increments on `tick` while `stable[i]` = 1 and saturates at `LONG_TICKS`.
  - On reaching `LONG_TICKS` it pulses `pb_long[i]` for one cycle, exactly once per press.
  - The counter clears when `stable[i]` = 0.
- **Not defined:** the hold counters are absent and `pb_long` is tied to 0. The port list is unchanged.

## Structure
- **Shared constants** go in the shared GPIO package/config header: default `TICK_HZ`, default `DEBOUNCE_TICKS`, and the polarity constant. `SOURCE_CLK` stays in the existing config.
- **Sub-module `gpio_tick_gen`:** parametrised by `SRC_CLK`/`TICK_HZ`, outputs the single-cycle `tick` enable, and is reusable by other GPIO blocks.
- **Filter:** the per-channel filter is a generate loop inside `gpio_debounce_bank`, not a separate module.

## Test plan
Bench parameters: `SRC_CLK`=1000, `TICK_HZ`=100 (tick every 10 cycles), `DEBOUNCE_TICKS`=4, `LONG_TICKS`=10, `ACTIVE_LOW`=1, `CHANNELS`=4.
1. Reset then idle with `pb_in`=4'hF: all outputs stay 0 for 200 cycles.
2. Drive `pb_in[0]`=0 and hold: `pb_level[0]` rises and `pb_press[0]` pulses once, on the 4th tick after synchronisation. Releasing with `pb_in[0]`=1 produces one `pb_release[0]` after 4 more ticks.
3. Bounce on ch1: toggle `pb_in[1]` every 15 cycles for 100 cycles, then hold 0. No event occurs during bouncing, and exactly one `pb_press[1]` occurs 4 ticks after the final edge.
4. Press ch2 and ch3 on the same cycle: `pb_press[2]` and `pb_press[3]` pulse in the same cycle. Ch0 and ch1 stay quiet.
5. Assert `rst_n`=0 mid-count on ch0 (after 2 ticks) while holding `pb_in[0]`=0, then release reset: all outputs are 0 immediately. `pb_press[0]` arrives 4 ticks after reset release, with no `pb_release`.
6. With `GPIO_DEBOUNCE_LONG_EN`, hold ch0 for 20 ticks: `pb_long[0]` pulses once, 10 ticks after `pb_press[0]`. Without the macro, `pb_long` stays 0.
